// File: rtl/cp0_timer_bridge.sv
// cp0_timer_bridge: exception/interrupt and MMIO back end of the 5-stage MIPS core.
//   CP0 (SR, Cause, EPC, PRId), a bridge that decodes load/store addresses into
//   two countdown-timer windows, and the two timers whose IRQs feed CP0.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ext_int                          external interrupt (HW interrupt bit 2)
//   cp0_op/cp0_addr/cp0_wdata        MFC0/MTC0/ERET request from the pipeline
//   exc_in/bd/epc_in                 pending exception of the MEM instruction
//   vaddr/mem_type/mem_mode/mem_wdata  load/store access from MEM
//   int_req                          flush to handler this cycle
//   epc_out/cp0_rdata                EPC and MFC0 read data
//   dev_hit/dev_rdata/dev_exc        timer window hit, timer read data, AdEL/AdES

// Countdown timer: CTRL (IM, MODE, EN), PRESET and read-only COUNT.
//   we/offset/wdata write port, rdata combinational read, irq = flag & IM.
module cp0_timer_bridge_tc (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_t;

   tc_state_t   state_r, state_s;
   logic [3:0]  ctrl_r, ctrl_s;
   logic [31:0] preset_r, preset_s;
   logic [31:0] count_r, count_s;
   logic        flag_r, flag_s;

   // Timer state and register file update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         ctrl_r   <= 4'd0;
         preset_r <= 32'd0;
         count_r  <= 32'd0;
         flag_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         ctrl_r   <= ctrl_s;
         preset_r <= preset_s;
         count_r  <= count_s;
         flag_r   <= flag_s;
      end
   end

   // Next state: a register write freezes the counting FSM for that cycle
   always_comb begin
      state_s  = state_r;
      ctrl_s   = ctrl_r;
      preset_s = preset_r;
      count_s  = count_r;
      flag_s   = flag_r;
      if (we) begin
         case (offset)
            2'd0:    ctrl_s   = wdata[3:0];
            2'd1:    preset_s = wdata;
            default: ctrl_s   = ctrl_r;
         endcase
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ctrl_r[0]) begin
                  state_s = ST_LOAD;
                  flag_s  = 1'b0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               count_s = preset_r;
               state_s = ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_r[0]) begin
                  state_s = ST_IDLE;
               end else if (count_r > 32'd1) begin
                  count_s = count_r - 32'd1;
               end else begin
                  count_s = 32'd0;
                  flag_s  = 1'b1;
                  state_s = ST_INT;
               end
            end
            ST_INT: begin
               state_s = ST_IDLE;
               // mode 0 is one-shot (flag held until next LOAD); others auto-reload
               if (ctrl_r[2:1] == 2'd0) begin
                  ctrl_s[0] = 1'b0;
               end else begin
                  flag_s = 1'b0;
               end
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // Register read mux
   always_comb begin
      case (offset)
         2'd0:    rdata = {28'd0, ctrl_r};
         2'd1:    rdata = preset_r;
         2'd2:    rdata = count_r;
         default: rdata = 32'd0;
      endcase
   end

   assign irq = flag_r & ctrl_r[3];
endmodule

module cp0_timer_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic        ext_int,
   input  logic [1:0]  cp0_op,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  exc_in,
   input  logic        bd,
   input  logic [31:0] epc_in,
   input  logic [31:0] vaddr,
   input  logic [1:0]  mem_type,
   input  logic [1:0]  mem_mode,
   input  logic [31:0] mem_wdata,
   output logic        int_req,
   output logic [31:0] epc_out,
   output logic [31:0] cp0_rdata,
   output logic        dev_hit,
   output logic [31:0] dev_rdata,
   output logic [4:0]  dev_exc
);
   localparam logic [31:0] PRID    = 32'h2023_0007;
   localparam logic [1:0]  OP_MTC0 = 2'd2;
   localparam logic [1:0]  OP_ERET = 2'd3;

   logic [5:0]  im_r, ip_r, hw_int_s;
   logic        exl_r, ie_r, bd_r;
   logic [4:0]  exccode_r;
   logic [31:0] epc_r, epc_target_s;
   logic        irq_s, excq_s, t0_irq_s, t1_irq_s;
   logic        hit0_s, hit1_s, store_s, in_ram_s, we_s;
   logic [1:0]  off_s;
   logic [4:0]  acc_code_s, dev_exc_s;
   logic [31:0] t0_rdata_s, t1_rdata_s;

   assign hw_int_s     = {3'b000, ext_int, t1_irq_s, t0_irq_s};
   assign irq_s        = (|(hw_int_s & im_r)) & ie_r & ~exl_r;
   assign excq_s       = (exc_in != 5'd0) & ~exl_r;
   assign int_req      = irq_s | excq_s;
   // a delay-slot instruction restarts at its branch
   assign epc_target_s = bd ? (epc_in - 32'd4) : epc_in;
   assign epc_out      = epc_r;

   // CP0 register update; taking an exception overrides MTC0/ERET
   always_ff @(posedge clk) begin
      if (reset) begin
         im_r      <= 6'd0;
         exl_r     <= 1'b0;
         ie_r      <= 1'b0;
         bd_r      <= 1'b0;
         ip_r      <= 6'd0;
         exccode_r <= 5'd0;
         epc_r     <= 32'd0;
      end else begin
         ip_r <= hw_int_s;
         if (int_req) begin
            exl_r     <= 1'b1;
            exccode_r <= irq_s ? 5'd0 : exc_in;
            bd_r      <= bd;
            epc_r     <= {epc_target_s[31:2], 2'b00};
         end else if (cp0_op == OP_MTC0) begin
            case (cp0_addr)
               5'd12: begin
                  im_r  <= cp0_wdata[15:10];
                  exl_r <= cp0_wdata[1];
                  ie_r  <= cp0_wdata[0];
               end
               5'd14:   epc_r <= cp0_wdata;
               default: epc_r <= epc_r;
            endcase
         end else if (cp0_op == OP_ERET) begin
            exl_r <= 1'b0;
         end else begin
            exl_r <= exl_r;
         end
      end
   end

   // MFC0 read mux
   always_comb begin
      case (cp0_addr)
         5'd12:   cp0_rdata = {16'd0, im_r, 8'd0, exl_r, ie_r};
         5'd13:   cp0_rdata = {bd_r, 15'd0, ip_r, 3'd0, exccode_r, 2'd0};
         5'd14:   cp0_rdata = epc_r;
         5'd15:   cp0_rdata = PRID;
         default: cp0_rdata = 32'd0;
      endcase
   end

   assign hit0_s     = (vaddr >= 32'h0000_7F00) && (vaddr <= 32'h0000_7F0B);
   assign hit1_s     = (vaddr >= 32'h0000_7F10) && (vaddr <= 32'h0000_7F1B);
   assign dev_hit    = hit0_s | hit1_s;
   assign off_s      = vaddr[3:2];
   assign store_s    = (mem_mode == 2'd2);
   assign in_ram_s   = (vaddr <= 32'h0000_2FFF);
   assign acc_code_s = store_s ? 5'd5 : 5'd4;

   // Bridge access checks: sub-word device access, COUNT store, unmapped address
   always_comb begin
      dev_exc_s = 5'd0;
      if (mem_mode != 2'd0) begin
         if (dev_hit && (mem_type != 2'd0)) begin
            dev_exc_s = acc_code_s;
         end else if (store_s && dev_hit && (off_s == 2'd2)) begin
            dev_exc_s = 5'd5;
         end else if (!in_ram_s && !dev_hit) begin
            dev_exc_s = acc_code_s;
         end else begin
            dev_exc_s = 5'd0;
         end
      end else begin
         dev_exc_s = 5'd0;
      end
   end

   assign dev_exc = dev_exc_s;
   // a flushed instruction must not leave a side effect in a timer
   assign we_s    = store_s & dev_hit & (dev_exc_s == 5'd0) & ~int_req;

   // Device read data select
   always_comb begin
      if (hit0_s) begin
         dev_rdata = t0_rdata_s;
      end else if (hit1_s) begin
         dev_rdata = t1_rdata_s;
      end else begin
         dev_rdata = 32'd0;
      end
   end

   cp0_timer_bridge_tc u_tc0 (
      .clk    (clk),
      .reset  (reset),
      .we     (we_s & hit0_s),
      .offset (off_s),
      .wdata  (mem_wdata),
      .rdata  (t0_rdata_s),
      .irq    (t0_irq_s)
   );

   cp0_timer_bridge_tc u_tc1 (
      .clk    (clk),
      .reset  (reset),
      .we     (we_s & hit1_s),
      .offset (off_s),
      .wdata  (mem_wdata),
      .rdata  (t1_rdata_s),
      .irq    (t1_irq_s)
   );
endmodule

// File: tb/tb_cp0_timer_bridge.sv
// Self-checking bench for cp0_timer_bridge: a vector table for single-cycle
// behaviour plus hand-written sequences for timers and exception entry.
module tb_cp0_timer_bridge;
   logic        clk = 1'b0;
   logic        reset;
   logic        ext_int;
   logic [1:0]  cp0_op;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [4:0]  exc_in;
   logic        bd;
   logic [31:0] epc_in;
   logic [31:0] vaddr;
   logic [1:0]  mem_type;
   logic [1:0]  mem_mode;
   logic [31:0] mem_wdata;
   logic        int_req;
   logic [31:0] epc_out;
   logic [31:0] cp0_rdata;
   logic        dev_hit;
   logic [31:0] dev_rdata;
   logic [4:0]  dev_exc;

   always #5 clk = ~clk;

   cp0_timer_bridge dut (
      .clk(clk), .reset(reset), .ext_int(ext_int), .cp0_op(cp0_op),
      .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .exc_in(exc_in), .bd(bd),
      .epc_in(epc_in), .vaddr(vaddr), .mem_type(mem_type), .mem_mode(mem_mode),
      .mem_wdata(mem_wdata), .int_req(int_req), .epc_out(epc_out),
      .cp0_rdata(cp0_rdata), .dev_hit(dev_hit), .dev_rdata(dev_rdata),
      .dev_exc(dev_exc)
   );

   typedef struct packed {
      logic [1:0]  op;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [4:0]  exc;
      logic        bd;
      logic [31:0] epc;
      logic        ext;
      logic [31:0] vaddr;
      logic [1:0]  mtype;
      logic [1:0]  mmode;
      logic [31:0] mwdata;
   } vec_t;

   typedef struct packed {
      int          tag;
      logic [5:0]  mask;
      logic        ir;
      logic [31:0] rd;
      logic [31:0] epc;
      logic        hit;
      logic [31:0] drd;
      logic [4:0]  dexc;
   } exp_t;

   typedef struct packed {
      vec_t v;
      exp_t e;
   } row_t;

   localparam logic [5:0] M_IR = 6'd1, M_RD = 6'd2, M_EPC = 6'd4;
   localparam logic [5:0] M_HIT = 6'd8, M_DRD = 6'd16, M_EXC = 6'd32;
   localparam logic [5:0] M_DEV = 6'd56;
   localparam logic [1:0] OP_N = 2'd0, OP_MF = 2'd1, OP_MT = 2'd2, OP_ER = 2'd3;
   localparam logic [1:0] LD = 2'd1, ST = 2'd2, W = 2'd0, H = 2'd1, B = 2'd2;

   row_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   tag_n = 0;

   function automatic vec_t cp(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
      vec_t v;
      v = '0;
      v.op = op;
      v.addr = a;
      v.wdata = d;
      return v;
   endfunction

   function automatic vec_t mm(input vec_t vi, input logic [1:0] mode, input logic [1:0] typ,
                               input logic [31:0] va, input logic [31:0] d);
      vec_t v;
      v = vi;
      v.mmode = mode;
      v.mtype = typ;
      v.vaddr = va;
      v.mwdata = d;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic [4:0] c, input logic b,
                               input logic [31:0] pc, input logic e);
      vec_t v;
      v = vi;
      v.exc = c;
      v.bd = b;
      v.epc = pc;
      v.ext = e;
      return v;
   endfunction

   function automatic exp_t ev(input logic [5:0] m, input logic ir, input logic [31:0] rd,
                               input logic [31:0] epc, input logic hit, input logic [31:0] drd,
                               input logic [4:0] dexc);
      exp_t e;
      e.tag = 0;
      e.mask = m;
      e.ir = ir;
      e.rd = rd;
      e.epc = epc;
      e.hit = hit;
      e.drd = drd;
      e.dexc = dexc;
      return e;
   endfunction

   task automatic add(input vec_t v, input exp_t e);
      row_t r;
      r.v = v;
      r.e = e;
      tbl.push_back(r);
   endtask

   task automatic drive(input vec_t v);
      cp0_op = v.op;
      cp0_addr = v.addr;
      cp0_wdata = v.wdata;
      exc_in = v.exc;
      bd = v.bd;
      epc_in = v.epc;
      ext_int = v.ext;
      vaddr = v.vaddr;
      mem_type = v.mtype;
      mem_mode = v.mmode;
      mem_wdata = v.mwdata;
   endtask

   task automatic check(input exp_t e);
      if (e.mask[0]) begin
         total++;
         if (int_req !== e.ir) begin
            bad++;
            $display("FAIL step%0d int_req got=%0h exp=%0h", e.tag, int_req, e.ir);
         end
      end
      if (e.mask[1]) begin
         total++;
         if (cp0_rdata !== e.rd) begin
            bad++;
            $display("FAIL step%0d cp0_rdata got=%08h exp=%08h", e.tag, cp0_rdata, e.rd);
         end
      end
      if (e.mask[2]) begin
         total++;
         if (epc_out !== e.epc) begin
            bad++;
            $display("FAIL step%0d epc_out got=%08h exp=%08h", e.tag, epc_out, e.epc);
         end
      end
      if (e.mask[3]) begin
         total++;
         if (dev_hit !== e.hit) begin
            bad++;
            $display("FAIL step%0d dev_hit got=%0h exp=%0h", e.tag, dev_hit, e.hit);
         end
      end
      if (e.mask[4]) begin
         total++;
         if (dev_rdata !== e.drd) begin
            bad++;
            $display("FAIL step%0d dev_rdata got=%08h exp=%08h", e.tag, dev_rdata, e.drd);
         end
      end
      if (e.mask[5]) begin
         total++;
         if (dev_exc !== e.dexc) begin
            bad++;
            $display("FAIL step%0d dev_exc got=%0d exp=%0d", e.tag, dev_exc, e.dexc);
         end
      end
   endtask

   // One cycle: drive, queue expectation, compare at the falling edge
   task automatic cyc(input vec_t v, input exp_t ei);
      exp_t e;
      exp_t got;
      e = ei;
      e.tag = tag_n;
      tag_n++;
      drive(v);
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      check(got);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t idle;
      logic [31:0] exp_cnt;
      logic [31:0] exp_cause;
      int p;
      idle = cp(OP_N, 5'd0, 32'd0);

      // CP0 reset state and plain reads
      add(cp(OP_MF, 5'd15, 32'd0), ev(6'h3F, 1'b0, 32'h2023_0007, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd12, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd13, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd14, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd7, 32'd0), ev(M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      // bridge decode and access checks
      add(mm(idle, ST, W, 32'h7F14, 32'hABCD_1234), ev(M_IR | M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0));
      add(mm(idle, LD, W, 32'h7F14, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'hABCD_1234, 5'd0));
      add(mm(idle, ST, H, 32'h7F04, 32'd7), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd5));
      add(mm(idle, LD, W, 32'h7F04, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0));
      add(mm(idle, ST, W, 32'h7F08, 32'd1), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd5));
      add(mm(idle, LD, W, 32'h6000, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd4));
      add(mm(idle, LD, W, 32'h7F1C, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd4));
      add(mm(idle, LD, W, 32'h7F0C, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd4));
      add(mm(idle, LD, W, 32'h7F0B, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0));
      add(mm(idle, ST, B, 32'h1000, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(mm(idle, LD, B, 32'h2FFF, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(mm(idle, LD, W, 32'h3000, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd4));
      add(mm(idle, ST, W, 32'h3000, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd5));
      add(mm(idle, 2'd0, W, 32'h6000, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(mm(idle, LD, B, 32'h7F10, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd4));
      add(mm(idle, ST, W, 32'h7F18, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd5));
      add(mm(idle, LD, W, 32'hFFFF_7F00, 32'd0), ev(M_DEV, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd4));
      // MTC0 register behaviour
      add(cp(OP_MT, 5'd14, 32'h1234_5678), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd14, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MT, 5'd13, 32'hFFFF_FFFF), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd13, 32'd0), ev(M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MT, 5'd12, 32'hFFFF_FFFF), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd12, 32'd0), ev(M_IR | M_RD, 1'b0, 32'h0000_FC03, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MT, 5'd12, 32'd0), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd12, 32'd0), ev(M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      // exception entry in a delay slot, EXL masking, ERET
      add(ex(cp(OP_MF, 5'd12, 32'd0), 5'd10, 1'b1, 32'h3008, 1'b0), ev(M_IR | M_RD | M_EPC, 1'b1, 32'd0, 32'h1234_5678, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd13, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'h8000_0028, 32'h3004, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd12, 32'd0), ev(M_RD, 1'b0, 32'h2, 32'd0, 1'b0, 32'd0, 5'd0));
      add(ex(cp(OP_MF, 5'd14, 32'd0), 5'd4, 1'b0, 32'h5000, 1'b0), ev(M_IR | M_RD, 1'b0, 32'h3004, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_ER, 5'd0, 32'd0), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd12, 32'd0), ev(M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(ex(cp(OP_MT, 5'd14, 32'h3100), 5'd4, 1'b0, 32'h3202, 1'b0), ev(M_IR, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd14, 32'd0), ev(M_RD | M_EPC, 1'b0, 32'h3200, 32'h3200, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd13, 32'd0), ev(M_RD, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_ER, 5'd0, 32'd0), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      add(cp(OP_MF, 5'd12, 32'd0), ev(M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));

      drive(idle);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].v, tbl[i].e);
      end

      // timer0 one-shot: SR IM0|IE, PRESET 5, CTRL 0x9
      cyc(mm(cp(OP_MT, 5'd12, 32'h401), ST, W, 32'h7F04, 32'd5), ev(M_IR | M_DEV, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0));
      cyc(mm(cp(OP_MF, 5'd12, 32'd0), ST, W, 32'h7F00, 32'h9), ev(M_IR | M_RD | M_DRD, 1'b0, 32'h401, 32'd0, 1'b0, 32'd0, 5'd0));
      for (int k = 1; k <= 7; k++) begin
         exp_cnt = (k <= 2) ? 32'd0 : (32'd8 - k);
         cyc(mm(cp(OP_MF, 5'd13, 32'd0), LD, W, 32'h7F08, 32'd0), ev(M_IR | M_RD | M_DRD, 1'b0, 32'h10, 32'd0, 1'b0, exp_cnt, 5'd0));
      end
      // IRQ cycle with a concurrent exception, MTC0 EPC and timer store
      cyc(mm(ex(cp(OP_MT, 5'd14, 32'h3100), 5'd10, 1'b0, 32'h3040, 1'b0), ST, W, 32'h7F04, 32'h99),
          ev(M_IR | M_EPC | M_DEV, 1'b1, 32'd0, 32'h3200, 1'b1, 32'd5, 5'd0));
      cyc(mm(cp(OP_MF, 5'd13, 32'd0), LD, W, 32'h7F00, 32'd0), ev(M_IR | M_RD | M_EPC | M_DRD, 1'b0, 32'h400, 32'h3040, 1'b0, 32'h8, 5'd0));
      cyc(mm(ex(cp(OP_MF, 5'd12, 32'd0), 5'd4, 1'b0, 32'h3300, 1'b0), LD, W, 32'h7F04, 32'd0), ev(M_IR | M_RD | M_DRD, 1'b0, 32'h403, 32'd0, 1'b0, 32'd5, 5'd0));
      cyc(cp(OP_MF, 5'd13, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'h400, 32'h3040, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MT, 5'd12, 32'h1), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(mm(cp(OP_MF, 5'd12, 32'd0), ST, W, 32'h7F00, 32'd0), ev(M_IR | M_RD, 1'b0, 32'h1, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MF, 5'd13, 32'd0), ev(M_RD, 1'b0, 32'h400, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MF, 5'd13, 32'd0), ev(M_IR | M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));

      // timer1 auto-reload: PRESET 3, CTRL 0xB, pulse every 6 cycles
      cyc(mm(idle, ST, W, 32'h7F14, 32'd3), ev(M_IR | M_HIT | M_EXC, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0));
      cyc(mm(idle, ST, W, 32'h7F10, 32'hB), ev(M_IR | M_EXC, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 5'd0));
      for (int k = 1; k <= 14; k++) begin
         p = (k - 1) % 6;
         exp_cnt = (p == 2) ? 32'd3 : (p == 3) ? 32'd2 : (p == 4) ? 32'd1 : 32'd0;
         exp_cause = ((p == 0) && (k > 1)) ? 32'h800 : 32'd0;
         cyc(mm(cp(OP_MF, 5'd13, 32'd0), LD, W, 32'h7F18, 32'd0), ev(M_IR | M_RD | M_DRD, 1'b0, exp_cause, 32'd0, 1'b0, exp_cnt, 5'd0));
      end
      cyc(mm(idle, ST, W, 32'h7F10, 32'd0), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));

      // external interrupt on HW bit 2
      cyc(ex(cp(OP_MF, 5'd13, 32'd0), 5'd0, 1'b0, 32'd0, 1'b1), ev(M_IR | M_RD, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MF, 5'd13, 32'd0), ev(M_RD, 1'b0, 32'h1000, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MT, 5'd12, 32'h1001), ev(M_IR, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(ex(cp(OP_MF, 5'd12, 32'd0), 5'd0, 1'b0, 32'h4000, 1'b1), ev(M_IR | M_RD, 1'b1, 32'h1001, 32'd0, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MF, 5'd13, 32'd0), ev(M_IR | M_RD | M_EPC, 1'b0, 32'h1000, 32'h4000, 1'b0, 32'd0, 5'd0));
      cyc(cp(OP_MF, 5'd12, 32'd0), ev(M_RD, 1'b0, 32'h1003, 32'd0, 1'b0, 32'd0, 5'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
